ysyx_22051468_ifu: RTL and testbench
====================================

# ysyx_22051468_ifu

Instruction fetch unit for the ysyx_22051468 core. Holds the PC, issues 32-bit instruction reads on a valid/ready memory request channel, buffers returned instructions in a small FIFO, and presents `{inst, inst_addr}` to the decode stage with a valid/ready handshake. It also accepts redirects (branch, jump, trap) from the execute stage, and squashes any stale in-flight or buffered instructions when one arrives.

## Interface
- `WIDTH`, 64: address/PC width.
- `RESET_PC`, 64'h8000_0000: PC value loaded at reset.
- `FIFO_DEPTH`, 2: instruction buffer entries; a power of two and ≥ 2.
- Clocking: one clock, `clk`. Reset is `rst_n`, asynchronous and active-low.
- `clk`  in  1  core clock.
- `rst_n`  in  1  async active-low reset.
- `redirect_valid_i`  in  1  redirect the fetch stream this cycle.
- `redirect_pc_i`  in  WIDTH  new fetch target.
- `mem_req_valid_o`  out  1  fetch request valid.
- `mem_req_addr_o`  out  WIDTH  fetch address, 4-byte aligned.
- `mem_req_ready_i`  in  1  memory accepts the request.
- `mem_rsp_valid_i`  in  1  instruction word returned; always accepted, with no ready signal.
- `mem_rsp_data_i`  in  32  instruction word.
- `inst_valid_o`  out  1  FIFO head valid, toward decode.
- `inst_o`  out  32  instruction at FIFO head.
- `inst_addr_o`  out  WIDTH  PC of `inst_o`.
- `inst_ready_i`  in  1  decode consumes the head.
- `misalign_o`  out  1  misaligned redirect detected. Present only with `YSYX_22051468_IFU_MISALIGN_EN`.

## Operation
- **Outstanding requests:** at most one request is outstanding at a time, from acceptance to response.
- **States:**
  - `S_IDLE`: no request pending.
  - `S_REQ`: `mem_req_valid_o` is high, waiting for ready.
  - `S_WAIT`: the request was accepted and the response is pending.
  - `S_HALT`: fetch is stopped; exists only with the macro.
- **S_IDLE → S_REQ:** when `fifo_count + 0 < FIFO_DEPTH`, so a slot is reserved for the response.
  - `mem_req_addr_o` = `pc`.
- **S_REQ → S_WAIT:** on `valid & ready`. The request is held stable (valid and addr) until accepted, even across a redirect.
- **S_WAIT:** on `mem_rsp_valid_i`:
  - push `{data, req_pc}` unless `drop` is set;
  - set `pc <= req_pc + 4`;
  - go to `S_IDLE`, or go directly to `S_REQ` if a slot would remain free after the push.
- **Redirect handling:**
  - The FIFO is flushed and `pc <= redirect_pc_i`.
  - If a request is pending (`S_REQ`, or `S_WAIT` without a response this cycle), `drop <= 1`.
  - The dropped response is discarded, `drop` clears, and fetch resumes from the redirected `pc`.
- **Simultaneous events:**
  - Redirect in the same cycle as a response: the response is discarded and `drop` is not set.
  - Redirect in the same cycle as a decode handshake: flush wins.
  - Push and pop in the same cycle: count is unchanged; a push into a full FIFO cannot happen because of the slot reservation.
- **FIFO:** read/write pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. The count is 1 bit wider.
- **PC arithmetic:** `pc + 4` is modulo 2^WIDTH, so wrap-around is legal.

## Timing
- **Reset values:**
  - `pc = RESET_PC`, state `S_IDLE`, `drop = 0`, FIFO empty;
  - `mem_req_valid_o = 0`, `inst_valid_o = 0`, `misalign_o = 0`;
  - `mem_req_addr_o`, `inst_o` and `inst_addr_o` read 0.
- **After reset:** the first `mem_req_valid_o` rises in the first cycle after `rst_n` deasserts.
- **Response latency:** a response sampled at edge N gives `inst_valid_o` from cycle N+1, because the FIFO output is registered.
- **Redirect latency:** a redirect at edge N gives `inst_valid_o = 0` in cycle N+1. The first request to the new PC goes out no earlier than cycle N+1 if idle, or the cycle after the dropped response otherwise.
- **Reset mid-operation:** reset asserted mid-transaction clears everything immediately. A memory response arriving after reset is ignored because state is `S_IDLE`.

## Configuration
- **`YSYX_22051468_IFU_MISALIGN_EN` defined:**
  - a redirect with `redirect_pc_i[1:0] != 0` sets `misalign_o` (sticky) and enters `S_HALT`;
  - no requests are issued in `S_HALT`, and any pending response is still drained and dropped;
  - a later aligned redirect clears `misalign_o` and resumes fetch.
- **Not defined:** the port and `S_HALT` are absent, and `redirect_pc_i[1:0]` are forced to 0.

## Test plan
- **Reset fetch:** release reset with memory ready and 1-cycle response → requests at 0x8000_0000, 0x8000_0004, …. Decode sees `inst_addr_o` in order with matching data.
- **Backpressure:** hold `inst_ready_i = 0` → after two responses the FIFO is full, `mem_req_valid_o` stays 0, and no instruction is lost once ready returns.
- **Redirect during WAIT:** redirect to 0x8000_0100 while a response is pending → the old response is discarded, the next request address is 0x8000_0100, and the first decoded `inst_addr_o` is 0x8000_0100.
- **Redirect vs response:** redirect in the same cycle as `mem_rsp_valid_i` → the response is not pushed, `drop` stays 0, and the next request goes to the target.
- **PC wrap:** reset with `RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC` → the second request address is 0.
- **Misaligned redirect (macro on):** redirect to 0x8000_0102 → `misalign_o = 1` and no requests are issued. A redirect to 0x8000_0200 then clears it and fetch resumes.

Source files
------------

// File: rtl/ysyx_22051468_ifu.sv
// Instruction fetch unit: PC, single-outstanding fetch channel, registered instruction FIFO, redirect squash.
// Optional misaligned-redirect halt enabled by defining YSYX_22051468_IFU_MISALIGN_EN.
module ysyx_22051468_ifu #(
    parameter int unsigned      WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(64'h8000_0000),
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_valid_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             mem_req_valid_o,
    output logic [WIDTH-1:0] mem_req_addr_o,
    input  logic             mem_req_ready_i,
    input  logic             mem_rsp_valid_i,
    input  logic [31:0]      mem_rsp_data_i,
    output logic             inst_valid_o,
    output logic [31:0]      inst_o,
    output logic [WIDTH-1:0] inst_addr_o,
    input  logic             inst_ready_i
`ifdef YSYX_22051468_IFU_MISALIGN_EN
    ,
    output logic             misalign_o
`endif
);

    localparam int unsigned   AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
`ifdef YSYX_22051468_IFU_MISALIGN_EN
        ,
        S_HALT = 2'd3
`endif
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             drop;
    logic             drop_nxt;
    logic             rsp_fire;
    logic             push;
    logic             pop;
    logic             launch;
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    cnt_push;
    logic [CW-1:0]    cnt_nxt;
`ifdef YSYX_22051468_IFU_MISALIGN_EN
    logic             misalign_nxt;
`endif

    // Next PC, drop flag, FIFO bookkeeping and request-launch decision
    always_comb begin
`ifdef YSYX_22051468_IFU_MISALIGN_EN
        tgt          = redirect_pc_i;
        misalign_nxt = redirect_valid_i ? (redirect_pc_i[1:0] != 2'b00) : misalign_o;
`else
        tgt          = {redirect_pc_i[WIDTH-1:2], redirect_pc_i[1:0] & 2'b00};
`endif
        pc_plus4 = mem_req_addr_o + WIDTH'(4);
        rsp_fire = (state == S_WAIT) && mem_rsp_valid_i;
        push     = rsp_fire && !drop && !redirect_valid_i;
        pop      = inst_valid_o && inst_ready_i && !redirect_valid_i;
        cnt_push = fifo_count + CW'(push);
        cnt_nxt  = cnt_push - CW'(pop);
        rd_nxt   = rd_ptr + AW'(pop);

        next_pc = pc;
        if (redirect_valid_i) begin
            next_pc = tgt;
        end else if (push) begin
            next_pc = pc_plus4;
        end

        drop_nxt = drop;
        if (rsp_fire) begin
            drop_nxt = 1'b0;
        end else if (redirect_valid_i && (state == S_REQ || state == S_WAIT)) begin
            drop_nxt = 1'b1;
        end

        launch = 1'b0;
        case (state)
            S_IDLE:  launch = redirect_valid_i || (fifo_count < DEPTH_C);
            S_WAIT:  launch = mem_rsp_valid_i && (redirect_valid_i || (cnt_push < DEPTH_C));
`ifdef YSYX_22051468_IFU_MISALIGN_EN
            S_HALT:  launch = redirect_valid_i;
`endif
            default: launch = 1'b0;
        endcase
`ifdef YSYX_22051468_IFU_MISALIGN_EN
        if (misalign_nxt) begin
            launch = 1'b0;
        end
`endif
    end

    // Fetch FSM with registered request outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            pc              <= RESET_PC;
            drop            <= 1'b0;
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
`ifdef YSYX_22051468_IFU_MISALIGN_EN
            misalign_o      <= 1'b0;
`endif
        end else begin
            pc   <= next_pc;
            drop <= drop_nxt;
`ifdef YSYX_22051468_IFU_MISALIGN_EN
            misalign_o <= misalign_nxt;
`endif
            if (launch) begin
                state           <= S_REQ;
                mem_req_valid_o <= 1'b1;
                mem_req_addr_o  <= next_pc;
            end else begin
                case (state)
`ifdef YSYX_22051468_IFU_MISALIGN_EN
                    S_IDLE: if (misalign_nxt) state <= S_HALT;
`endif
                    S_REQ: begin
                        if (mem_req_ready_i) begin
                            state           <= S_WAIT;
                            mem_req_valid_o <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (mem_rsp_valid_i) begin
`ifdef YSYX_22051468_IFU_MISALIGN_EN
                            state <= misalign_nxt ? S_HALT : S_IDLE;
`else
                            state <= S_IDLE;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // FIFO pointers and registered head; a word landing in an empty FIFO becomes head directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_addr_o  <= '0;
        end else if (redirect_valid_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            inst_valid_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr       <= rd_nxt;
            fifo_count   <= cnt_nxt;
            inst_valid_o <= (cnt_nxt != '0);
            if (fifo_count == CW'(pop)) begin
                if (push) begin
                    inst_o      <= mem_rsp_data_i;
                    inst_addr_o <= mem_req_addr_o;
                end
            end else begin
                inst_o      <= fifo_data[rd_nxt];
                inst_addr_o <= fifo_addr[rd_nxt];
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_rsp_data_i;
            fifo_addr[wr_ptr] <= mem_req_addr_o;
        end
    end

endmodule

// File: tb/tb_ysyx_22051468_ifu.sv
// Directed bench for ysyx_22051468_ifu: fetch order, backpressure, redirects, PC wrap, reset.
module tb_ysyx_22051468_ifu;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;
    logic        mem_req_ready_i;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        inst_ready_i;

    logic        mem_req_valid_o;
    logic [63:0] mem_req_addr_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [63:0] inst_addr_o;

    logic        w_req_valid;
    logic [63:0] w_req_addr;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [63:0] w_inst_addr;
`ifdef YSYX_22051468_IFU_MISALIGN_EN
    logic        misalign_o;
    logic        w_misalign;
`endif

    int errors = 0;
    int checks = 0;

    ysyx_22051468_ifu u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_rsp_valid_i  (mem_rsp_valid_i),
        .mem_rsp_data_i   (mem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .inst_addr_o      (inst_addr_o),
        .inst_ready_i     (inst_ready_i)
`ifdef YSYX_22051468_IFU_MISALIGN_EN
        ,
        .misalign_o       (misalign_o)
`endif
    );

    ysyx_22051468_ifu #(
        .RESET_PC (64'hFFFF_FFFF_FFFF_FFFC)
    ) u_wrap (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .mem_req_valid_o  (w_req_valid),
        .mem_req_addr_o   (w_req_addr),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_rsp_valid_i  (mem_rsp_valid_i),
        .mem_rsp_data_i   (mem_rsp_data_i),
        .inst_valid_o     (w_inst_valid),
        .inst_o           (w_inst),
        .inst_addr_o      (w_inst_addr),
        .inst_ready_i     (inst_ready_i)
`ifdef YSYX_22051468_IFU_MISALIGN_EN
        ,
        .misalign_o       (w_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n            = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        mem_req_ready_i  = 1'b1;
        mem_rsp_valid_i  = 1'b0;
        mem_rsp_data_i   = '0;
        inst_ready_i     = 1'b0;
        step();
        step();
        chk("rst_req_valid", 64'(mem_req_valid_o), 64'h0);
        chk("rst_req_addr", mem_req_addr_o, 64'h0);
        chk("rst_inst_valid", 64'(inst_valid_o), 64'h0);
        chk("rst_inst", 64'(inst_o), 64'h0);
        chk("rst_inst_addr", inst_addr_o, 64'h0);
`ifdef YSYX_22051468_IFU_MISALIGN_EN
        chk("rst_misalign", 64'(misalign_o), 64'h0);
`endif
        rst_n = 1'b1;

        // Reset fetch
        step();
        chk("e1_req_valid", 64'(mem_req_valid_o), 64'h1);
        chk("e1_req_addr", mem_req_addr_o, 64'h8000_0000);
        chk("e1_wrap_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("e2_req_valid", 64'(mem_req_valid_o), 64'h0);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = dat(64'h8000_0000);
        step();
        mem_rsp_valid_i = 1'b0;
        chk("e3_inst_valid", 64'(inst_valid_o), 64'h1);
        chk("e3_inst", 64'(inst_o), 64'(dat(64'h8000_0000)));
        chk("e3_inst_addr", inst_addr_o, 64'h8000_0000);
        chk("e3_req_addr", mem_req_addr_o, 64'h8000_0004);
        chk("e3_req_valid", 64'(mem_req_valid_o), 64'h1);
        chk("wrap_second_addr", w_req_addr, 64'h0);
        chk("wrap_inst_addr", w_inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);

        // Backpressure: FIFO fills, fetch stops
        step();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = dat(64'h8000_0004);
        step();
        mem_rsp_valid_i = 1'b0;
        chk("e5_req_valid", 64'(mem_req_valid_o), 64'h0);
        chk("e5_head_hold", inst_addr_o, 64'h8000_0000);
        step();
        chk("e6_req_valid", 64'(mem_req_valid_o), 64'h0);
        step();
        chk("e7_req_valid", 64'(mem_req_valid_o), 64'h0);
        chk("e7_inst", 64'(inst_o), 64'(dat(64'h8000_0000)));
        inst_ready_i = 1'b1;
        step();
        chk("e8_inst_valid", 64'(inst_valid_o), 64'h1);
        chk("e8_inst_addr", inst_addr_o, 64'h8000_0004);
        chk("e8_inst", 64'(inst_o), 64'(dat(64'h8000_0004)));
        chk("e8_req_valid", 64'(mem_req_valid_o), 64'h0);
        step();
        chk("e9_inst_valid", 64'(inst_valid_o), 64'h0);
        chk("e9_req_valid", 64'(mem_req_valid_o), 64'h1);
        chk("e9_req_addr", mem_req_addr_o, 64'h8000_0008);

        // Redirect during WAIT
        step();
        chk("e10_req_valid", 64'(mem_req_valid_o), 64'h0);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0100;
        step();
        redirect_valid_i = 1'b0;
        chk("e11_req_valid", 64'(mem_req_valid_o), 64'h0);
        chk("e11_inst_valid", 64'(inst_valid_o), 64'h0);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = dat(64'h8000_0008);
        step();
        mem_rsp_valid_i = 1'b0;
        chk("e12_stale_dropped", 64'(inst_valid_o), 64'h0);
        chk("e12_req_valid", 64'(mem_req_valid_o), 64'h1);
        chk("e12_req_addr", mem_req_addr_o, 64'h8000_0100);
        step();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = dat(64'h8000_0100);
        step();
        mem_rsp_valid_i = 1'b0;
        chk("e14_inst_valid", 64'(inst_valid_o), 64'h1);
        chk("e14_inst_addr", inst_addr_o, 64'h8000_0100);
        chk("e14_inst", 64'(inst_o), 64'(dat(64'h8000_0100)));
        chk("e14_req_addr", mem_req_addr_o, 64'h8000_0104);
        step();
        chk("e15_inst_valid", 64'(inst_valid_o), 64'h0);

        // Redirect in the same cycle as the response
        mem_rsp_valid_i  = 1'b1;
        mem_rsp_data_i   = dat(64'h8000_0104);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0200;
        step();
        mem_rsp_valid_i  = 1'b0;
        redirect_valid_i = 1'b0;
        chk("e16_inst_valid", 64'(inst_valid_o), 64'h0);
        chk("e16_req_valid", 64'(mem_req_valid_o), 64'h1);
        chk("e16_req_addr", mem_req_addr_o, 64'h8000_0200);
        step();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = dat(64'h8000_0200);
        step();
        mem_rsp_valid_i = 1'b0;
        chk("e18_not_dropped", 64'(inst_valid_o), 64'h1);
        chk("e18_inst_addr", inst_addr_o, 64'h8000_0200);

        // Redirect against a decode handshake: flush wins
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0300;
        step();
        redirect_valid_i = 1'b0;
        chk("e19_flush", 64'(inst_valid_o), 64'h0);
        chk("e19_req_valid", 64'(mem_req_valid_o), 64'h0);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = dat(64'h8000_0204);
        step();
        mem_rsp_valid_i = 1'b0;
        chk("e20_inst_valid", 64'(inst_valid_o), 64'h0);
        chk("e20_req_addr", mem_req_addr_o, 64'h8000_0300);

        // Request held stable across a redirect while not accepted
        mem_req_ready_i  = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0400;
        step();
        redirect_valid_i = 1'b0;
        chk("e21_hold_valid", 64'(mem_req_valid_o), 64'h1);
        chk("e21_hold_addr", mem_req_addr_o, 64'h8000_0300);
        mem_req_ready_i = 1'b1;
        step();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = dat(64'h8000_0300);
        step();
        mem_rsp_valid_i = 1'b0;
        chk("e23_inst_valid", 64'(inst_valid_o), 64'h0);
        chk("e23_req_addr", mem_req_addr_o, 64'h8000_0400);
        step();

        // Misaligned redirect
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0102;
        step();
        redirect_valid_i = 1'b0;
`ifdef YSYX_22051468_IFU_MISALIGN_EN
        chk("e25_misalign", 64'(misalign_o), 64'h1);
        chk("e25_req_valid", 64'(mem_req_valid_o), 64'h0);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = dat(64'h8000_0400);
        step();
        mem_rsp_valid_i = 1'b0;
        chk("e26_halt_valid", 64'(mem_req_valid_o), 64'h0);
        chk("e26_inst_valid", 64'(inst_valid_o), 64'h0);
        step();
        chk("e27_halt_valid", 64'(mem_req_valid_o), 64'h0);
        chk("e27_misalign", 64'(misalign_o), 64'h1);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0200;
        step();
        redirect_valid_i = 1'b0;
        chk("e28_misalign_clr", 64'(misalign_o), 64'h0);
        chk("e28_req_valid", 64'(mem_req_valid_o), 64'h1);
        chk("e28_req_addr", mem_req_addr_o, 64'h8000_0200);
`else
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = dat(64'h8000_0400);
        step();
        mem_rsp_valid_i = 1'b0;
        chk("e26_aligned_valid", 64'(mem_req_valid_o), 64'h1);
        chk("e26_aligned_addr", mem_req_addr_o, 64'h8000_0100);
`endif

        // Reset mid-operation, response during reset ignored
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", 64'(mem_req_valid_o), 64'h0);
        chk("mid_rst_req_addr", mem_req_addr_o, 64'h0);
        chk("mid_rst_inst_valid", 64'(inst_valid_o), 64'h0);
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'hDEAD_BEEF;
        step();
        rst_n = 1'b1;
        step();
        mem_rsp_valid_i = 1'b0;
        chk("post_rst_inst_valid", 64'(inst_valid_o), 64'h0);
        chk("post_rst_req_valid", 64'(mem_req_valid_o), 64'h1);
        chk("post_rst_req_addr", mem_req_addr_o, 64'h8000_0000);
        mem_req_ready_i = 1'b1;
        step();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = dat(64'h8000_0000);
        step();
        mem_rsp_valid_i = 1'b0;
        chk("post_rst_inst_addr", inst_addr_o, 64'h8000_0000);
        chk("post_rst_inst", 64'(inst_o), 64'(dat(64'h8000_0000)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
